mem_bridge: RTL

Parametrised memory bridge between the pipeline's zero-latency fetch/data ports and a single shared request/grant/response memory bus. It arbitrates instruction fetches and data loads/stores onto one port with at most one transaction outstanding. It generates byte enables, aligns store and load data, and returns a per-channel ready pulse plus a core-wide stall. It sits between the core's ifetch/exe memory interfaces and the SoC memory.

---
 rtl/mem_bridge.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_bridge.sv
// mem_bridge: arbitrates the core's fetch and data ports onto one request/grant/response
// memory bus, one transaction in flight, with byte-lane alignment of stores and loads.
module mem_bridge #(
    parameter int XLEN     = 32,
    parameter int ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_adr_i,
    output logic [31:0]       if_instr_o,
    output logic              if_rdy_o,
    input  logic              d_req_i,
    input  logic [XLEN-1:0]   d_adr_i,
    input  logic              d_is_store_i,
    input  logic [2:0]        d_size_i,
    input  logic [XLEN-1:0]   d_store_data_i,
    output logic [XLEN-1:0]   d_load_data_o,
    output logic              d_rdy_o,
    output logic              d_err_o,
    output logic              stall_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [XLEN-1:0]   mem_adr_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    input  logic              mem_err_i
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic            owner_d;
    logic            last_d;
    logic            err_q;
    logic            accept, pick_d, d_misaligned, resp;
    logic [XLEN-1:0] adr_q, wdata_q, rdata_q;
    logic [1:0]      size_q;
    logic            we_q;
    logic [OFFW-1:0] off;
    logic [XLEN-1:0] lane_data;
    logic            unused_size_msb;

    assign unused_size_msb = d_size_i[2];

    function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] sz);
        logic [2:0] m;
        m = 3'((4'd1 << sz) - 4'd1);
        return ((lo & m) != 3'd0) || (XLEN == 32 && sz == 2'd3);
    endfunction

    function automatic logic [NB-1:0] byte_en(input logic [OFFW-1:0] o, input logic [1:0] sz);
        logic [NB-1:0] be;
        be = '0;
        for (int b = 0; b < NB; b++)
            if (b >= int'(o) && b < int'(o) + (1 << sz)) be[b] = 1'b1;
        return be;
    endfunction

    function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
        logic [XLEN-1:0] m;
        m = '0;
        for (int b = 0; b < NB; b++)
            if (b < (1 << sz)) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    // Arbitration and next state
    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        pick_d       = 1'b0;
        d_misaligned = misaligned(d_adr_i[2:0], d_size_i[1:0]);
        case (state)
            IDLE: begin
                if (if_req_i || d_req_i) begin
                    accept    = 1'b1;
                    pick_d    = (ARB_MODE == 0) ? d_req_i
                                                : (d_req_i && (!if_req_i || !last_d));
                    state_nxt = (pick_d && d_misaligned) ? RESP : REQ;
                end
            end
            REQ:     if (mem_gnt_i) state_nxt = WAIT;
            WAIT:    if (mem_rvalid_i) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            last_d  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner_d <= pick_d;
                last_d  <= pick_d;
                err_q   <= pick_d && d_misaligned;
            end else if (state == WAIT && mem_rvalid_i) begin
                err_q <= mem_err_i;
            end
        end
    end

    // Latched transaction fields and response data
    always_ff @(posedge clk) begin
        if (accept) begin
            adr_q   <= pick_d ? d_adr_i : if_adr_i;
            we_q    <= pick_d && d_is_store_i;
            size_q  <= pick_d ? d_size_i[1:0] : 2'd2;
            wdata_q <= d_store_data_i;
        end
        if (state == WAIT && mem_rvalid_i) rdata_q <= mem_rdata_i;
    end

    // Bus drive and core-side response
    always_comb begin
        off         = adr_q[OFFW-1:0];
        mem_req_o   = (state == REQ);
        mem_adr_o   = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (state == REQ) begin
            mem_adr_o   = {adr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
            mem_we_o    = we_q;
            mem_be_o    = byte_en(off, size_q);
            mem_wdata_o = wdata_q << {off, 3'b000};
        end
        // A word-aligned fetch offset selects its 32-bit lane through the same shift
        lane_data     = rdata_q >> {off, 3'b000};
        resp          = (state == RESP);
        if_rdy_o      = resp && !owner_d;
        d_rdy_o       = resp && owner_d;
        d_err_o       = resp && owner_d && err_q;
        if_instr_o    = '0;
        d_load_data_o = '0;
        if (resp && !owner_d) if_instr_o = lane_data[31:0];
        if (resp && owner_d && !we_q && !err_q) d_load_data_o = lane_data & size_mask(size_q);
    end

    assign stall_o = (if_req_i & ~if_rdy_o) | (d_req_i & ~d_rdy_o);

endmodule
